up_counter: RTL and testbench
=============================

UP_COUNTER -- requirements
Module: up_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (1..32).
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal count; legal range 1..2**WIDTH-1.
REQ-003 Parameter RST_VAL, default 0, value loaded on reset; legal range 0..MAX_VAL.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 out  output  WIDTH  current count, driven directly from a register.
REQ-007 tc  output  1  terminal count; combinational, high while out == MAX_VAL.
REQ-008 wrap  output  1  registered pulse; high for exactly the one cycle after out wraps from MAX_VAL to 0.
REQ-009 en, ld, ld_val[WIDTH-1:0]  input  control ports; present only when UP_COUNTER_CTRL_EN is defined (see Configuration).
REQ-010 Default build (macro undefined) SHALL have exactly ports clk, rstn, out, tc, wrap, so that an instance connecting only clk, rstn and out is fully functional.

Function
REQ-011 On every rising clk edge with rstn high, out SHALL become out+1 when out < MAX_VAL, else 0.
REQ-012 Latency: out SHALL change on the first rising edge sampled with rstn high after reset release; no extra idle cycle.
REQ-013 tc SHALL be high combinationally while out == MAX_VAL, else low.
REQ-014 wrap SHALL be set on the edge at which out goes from MAX_VAL to 0, and cleared on the next edge unless another wrap occurs (possible only when MAX_VAL == 0 is excluded, so never back-to-back for MAX_VAL >= 1).
REQ-015 All arithmetic SHALL be WIDTH bits, unsigned; no value above MAX_VAL SHALL ever appear on out.
REQ-016 Reset asserted mid-count SHALL override counting on that edge: out = RST_VAL, wrap = 0.
REQ-017 For a non-power-of-two modulus (MAX_VAL < 2**WIDTH-1), the count SHALL wrap at MAX_VAL, not at the natural overflow.

Reset
REQ-018 While rstn is sampled low at a rising clk edge: out = RST_VAL, wrap = 0; tc follows out.
REQ-019 Reset SHALL have no effect between clock edges; before the first clk edge, out is undefined.
REQ-020 Reset SHALL take priority over every other input, including ld and en.

Configuration
REQ-021 Macro UP_COUNTER_CTRL_EN, when defined, SHALL add inputs en, ld and ld_val.
REQ-022 With the macro defined, priority SHALL be rstn, then ld, then en.
- ld = 1: out = ld_val, or MAX_VAL if ld_val > MAX_VAL; wrap = 0.
- ld = 0, en = 0: out holds; wrap = 0.
- ld = 0, en = 1: out counts per REQ-011.
REQ-023 Without the macro, behaviour SHALL be identical to the macro build with en tied 1 and ld tied 0.

Verification
REQ-024 Default params, 10-unit clk period, rstn = 0 for 20 units then 1 -> out = 0 during reset; out = 1 after the first edge with rstn high, then increments by 1 per cycle.
REQ-025 Run 16+ cycles after release -> out goes 0..15 and then 0; tc is high only at 15; wrap pulses for one cycle with out = 0.
REQ-026 Drive rstn low for one edge while out = 9 -> out = 0 on that edge; counting resumes 1, 2, ... afterwards.
REQ-027 WIDTH = 4, MAX_VAL = 9 -> sequence 0..9, 0; tc high at 9; out never exceeds 9.
REQ-028 RST_VAL = 5 -> out = 5 after reset, then 6, 7, ...
REQ-029 Macro defined -> check each case:
- en = 0: out holds.
- ld = 1, ld_val = 3, en = 1: out = 3 on the next edge.
- ld_val = 14 with MAX_VAL = 9: out = 9.
- rstn = 0 with ld = 1: out = RST_VAL.

Source files
------------

// File: rtl/up_counter.sv
// Modulo up-counter with terminal-count flag and a registered wrap pulse.
// Define UP_COUNTER_CTRL_EN to add the en/ld/ld_val control inputs.
module up_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
`ifdef UP_COUNTER_CTRL_EN
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_count_next;
  logic             w_wrap_next;
  logic             w_en;
  logic             w_ld;
  logic [WIDTH-1:0] w_ld_val;

`ifdef UP_COUNTER_CTRL_EN
  assign w_en     = en;
  assign w_ld     = ld;
  assign w_ld_val = ld_val;
`else
  assign w_en     = 1'b1;
  assign w_ld     = 1'b0;
  assign w_ld_val = '0;
`endif

  // Loads are clamped so out can never exceed the terminal count.
  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    if (w_ld) begin
      w_count_next = (w_ld_val > MAX_VAL) ? MAX_VAL : w_ld_val;
    end else if (w_en) begin
      if (r_count < MAX_VAL) begin
        w_count_next = r_count + ONE;
      end else begin
        w_count_next = '0;
        w_wrap_next  = (r_count == MAX_VAL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= RST_VAL;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_wrap  <= w_wrap_next;
    end
  end

  assign out  = r_count;
  assign tc   = (r_count == MAX_VAL);
  assign wrap = r_wrap;

endmodule

// File: tb/tb_up_counter.sv
// Directed bench for up_counter: default, modulo-10 and RST_VAL=5 instances
// share one clock and reset; control-port cases run when UP_COUNTER_CTRL_EN is set.
module tb_up_counter;

  logic       clk;
  logic       rstn;
  logic [3:0] out_def, out_m9, out_r5;
  logic       tc_def, tc_m9, tc_r5;
  logic       wrap_def, wrap_m9, wrap_r5;
`ifdef UP_COUNTER_CTRL_EN
  logic       en;
  logic       ld;
  logic [3:0] ld_val;
`endif

  int checks   = 0;
  int failures = 0;
  int e_def, e_m9, e_r5;
  int w_def, w_m9, w_r5;

  localparam int MAX_DEF = 15;
  localparam int MAX_M9  = 9;
  localparam int MAX_R5  = 15;

`ifdef UP_COUNTER_CTRL_EN
  up_counter u_dut_def (.clk(clk), .rstn(rstn), .en(en), .ld(ld), .ld_val(ld_val),
                        .out(out_def), .tc(tc_def), .wrap(wrap_def));
  up_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_dut_m9 (.clk(clk), .rstn(rstn), .en(en), .ld(ld),
                        .ld_val(ld_val), .out(out_m9), .tc(tc_m9), .wrap(wrap_m9));
  up_counter #(.WIDTH(4), .RST_VAL(4'd5)) u_dut_r5 (.clk(clk), .rstn(rstn), .en(en), .ld(ld),
                        .ld_val(ld_val), .out(out_r5), .tc(tc_r5), .wrap(wrap_r5));
`else
  up_counter u_dut_def (.clk(clk), .rstn(rstn), .out(out_def), .tc(tc_def), .wrap(wrap_def));
  up_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_dut_m9 (.clk(clk), .rstn(rstn),
                        .out(out_m9), .tc(tc_m9), .wrap(wrap_m9));
  up_counter #(.WIDTH(4), .RST_VAL(4'd5)) u_dut_r5 (.clk(clk), .rstn(rstn),
                        .out(out_r5), .tc(tc_r5), .wrap(wrap_r5));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    $display("[%0t] %s out=%0d/%0d/%0d wrap=%0b/%0b/%0b", $time, tag,
             out_def, out_m9, out_r5, wrap_def, wrap_m9, wrap_r5);
    check({tag, ".def.out"},  {28'd0, out_def}, e_def);
    check({tag, ".def.tc"},   {31'd0, tc_def},  (e_def == MAX_DEF) ? 1 : 0);
    check({tag, ".def.wrap"}, {31'd0, wrap_def}, w_def);
    check({tag, ".m9.out"},   {28'd0, out_m9},  e_m9);
    check({tag, ".m9.tc"},    {31'd0, tc_m9},   (e_m9 == MAX_M9) ? 1 : 0);
    check({tag, ".m9.wrap"},  {31'd0, wrap_m9}, w_m9);
    check({tag, ".r5.out"},   {28'd0, out_r5},  e_r5);
    check({tag, ".r5.tc"},    {31'd0, tc_r5},   (e_r5 == MAX_R5) ? 1 : 0);
    check({tag, ".r5.wrap"},  {31'd0, wrap_r5}, w_r5);
  endtask

  // mode 0: count, 1: hold, 2: load ld_v (clamped), 3: reset
  task automatic step(input string tag, input int mode, input int ld_v);
    case (mode)
      0: begin
        w_def = (e_def == MAX_DEF); e_def = w_def ? 0 : e_def + 1;
        w_m9  = (e_m9 == MAX_M9);   e_m9  = w_m9  ? 0 : e_m9 + 1;
        w_r5  = (e_r5 == MAX_R5);   e_r5  = w_r5  ? 0 : e_r5 + 1;
      end
      1: begin
        w_def = 0; w_m9 = 0; w_r5 = 0;
      end
      2: begin
        w_def = 0; w_m9 = 0; w_r5 = 0;
        e_def = (ld_v > MAX_DEF) ? MAX_DEF : ld_v;
        e_m9  = (ld_v > MAX_M9)  ? MAX_M9  : ld_v;
        e_r5  = (ld_v > MAX_R5)  ? MAX_R5  : ld_v;
      end
      default: begin
        w_def = 0; w_m9 = 0; w_r5 = 0;
        e_def = 0; e_m9 = 0; e_r5 = 5;
      end
    endcase
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rstn = 1'b0;
`ifdef UP_COUNTER_CTRL_EN
    en = 1'b1; ld = 1'b0; ld_val = 4'd0;
`endif
    // Reset held low for 20 time units; edges at 5 and 15 both see it.
    step("reset0", 3, 0);
    step("reset1", 3, 0);
    rstn = 1'b1;

    // Default counter sweeps 0..15 and wraps; mod-10 counter wraps at 9.
    for (int k = 1; k <= 25; k++) begin
      step($sformatf("count%0d", k), 0, 0);
    end

    // Default counter now at 9: one reset edge mid-count.
    rstn = 1'b0;
    step("midreset", 3, 0);
    rstn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step($sformatf("resume%0d", k), 0, 0);
    end

`ifdef UP_COUNTER_CTRL_EN
    en = 1'b0;
    step("hold1", 1, 0);
    step("hold2", 1, 0);
    en = 1'b1; ld = 1'b1; ld_val = 4'd3;
    step("load3", 2, 3);
    ld_val = 4'd14;
    step("load14", 2, 14);
    ld = 1'b0;
    step("afterload", 0, 0);
    rstn = 1'b0; ld = 1'b1; ld_val = 4'd7;
    step("rst_over_ld", 3, 0);
    rstn = 1'b1; ld = 1'b0;
    step("postrst", 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
